// File: rtl/cell_char_pkg.sv
// Shared types and defaults for the standard-cell characterization sequencers.
package cell_char_pkg;

   // Sweep controller states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2
   } state_t;

   // Default cell under characterization: 5-input OAI221 (IN1..IN5 -> QN).
   localparam int NIN_DEF        = 5;
   localparam int SETTLE_CYC_DEF = 2;

   // Number of input vectors in a full sweep of an n-input cell.
   function automatic int nvec(input int nin);
      return 2 ** nin;
   endfunction

   localparam int NVEC = nvec(NIN_DEF);

   // Width of the settle down-counter; it must hold SETTLE_CYC itself.
   function automatic int settle_width(input int settle_cyc);
      return (settle_cyc < 1) ? 1 : $clog2(settle_cyc + 1);
   endfunction

   // Truth table of QN = !((IN1|IN2) & (IN3|IN4) & IN5), bit k = output for input index k.
   localparam logic [31:0] TT_OAI221 = 32'h111F_FFFF;

endpackage

// File: rtl/cell_char_vecgen.sv
// Index to stimulus vector mapping, binary or reflected Gray order.
module cell_char_vecgen #(
   parameter int NIN = 5
) (
   input  logic [NIN-1:0] idx,
   input  logic           gray,
   output logic [NIN-1:0] vec
);

   // Gray order changes exactly one cell input between consecutive vectors.
   always_comb begin
      vec = idx;
      if (gray) begin
         vec = idx ^ (idx >> 1);
      end
   end

endmodule

// File: rtl/cell_char_sequencer.sv
// Sweeps a combinational cell through every input vector, samples its output after a
// settle time and accumulates toggle, ones and truth-table mismatch counts.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no sweep; VEC = 0, waiting for START
// SETTLE | current vector held on the cell inputs for SETTLE_CYC edges
// SAMPLE | next edge captures DUT_Q, updates counters, advances vector
module cell_char_sequencer
   import cell_char_pkg::*;
#(
   parameter int                  NIN        = NIN_DEF,
   parameter int                  SETTLE_CYC = SETTLE_CYC_DEF,
   parameter logic [(2**NIN)-1:0] TT         = TT_OAI221
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           START,
   input  logic           ABORT,
   input  logic           GRAY,
   output logic           BUSY,
   output logic           DONE,
   output logic [NIN-1:0] VEC,
   input  logic           DUT_Q,
   output logic [NIN:0]   TOGGLES,
   output logic [NIN:0]   ONES,
   output logic [NIN:0]   ERRS,
   output logic [NIN-1:0] FIRST_ERR_IDX,
   output logic           ERR_SEEN
);

   localparam int            SW        = settle_width(SETTLE_CYC);
   localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC);
   localparam logic [NIN-1:0] IDX_LAST = {NIN{1'b1}};

   state_t          state;
   state_t          state_nxt;
   logic [SW-1:0]   settle_cnt;
   logic [NIN-1:0]  idx;
   logic            gray_lat;
   logic            q_prev;

   logic            do_start;
   logic            do_abort;
   logic            do_sample;
   logic            do_finish;
   logic            cnt_dec;

   logic [NIN-1:0]  vg_idx;
   logic            vg_gray;
   logic [NIN-1:0]  vg_vec;
   logic            mismatch;

   // The generator always produces the vector about to be loaded: order(0) at start,
   // order(i+1) on a sample edge, using the order latched when the sweep began.
   always_comb begin
      vg_idx  = idx + NIN'(1);
      vg_gray = gray_lat;
      if (state == IDLE) begin
         vg_idx  = '0;
         vg_gray = GRAY;
      end
   end

   cell_char_vecgen #(
      .NIN (NIN)
   ) u_vecgen (
      .idx  (vg_idx),
      .gray (vg_gray),
      .vec  (vg_vec)
   );

   assign mismatch = (DUT_Q != TT[VEC]);

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and datapath strobes; ABORT is only honoured outside IDLE.
   always_comb begin
      state_nxt = state;
      do_start  = 1'b0;
      do_abort  = 1'b0;
      do_sample = 1'b0;
      do_finish = 1'b0;
      cnt_dec   = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               do_start  = 1'b1;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (ABORT) begin
               do_abort  = 1'b1;
               state_nxt = IDLE;
            end else if (settle_cnt == SW'(1)) begin
               state_nxt = SAMPLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         SAMPLE: begin
            if (ABORT) begin
               do_abort  = 1'b1;
               state_nxt = IDLE;
            end else begin
               do_sample = 1'b1;
               if (idx == IDX_LAST) begin
                  do_finish = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = SETTLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Vector sequencing, settle timer and result accumulators.
   always_ff @(posedge CLK) begin
      if (RST) begin
         BUSY          <= 1'b0;
         DONE          <= 1'b0;
         VEC           <= '0;
         TOGGLES       <= '0;
         ONES          <= '0;
         ERRS          <= '0;
         FIRST_ERR_IDX <= '0;
         ERR_SEEN      <= 1'b0;
         settle_cnt    <= '0;
         idx           <= '0;
         gray_lat      <= 1'b0;
         q_prev        <= 1'b0;
      end else begin
         DONE <= 1'b0;

         if (do_start) begin
            TOGGLES       <= '0;
            ONES          <= '0;
            ERRS          <= '0;
            FIRST_ERR_IDX <= '0;
            ERR_SEEN      <= 1'b0;
            gray_lat      <= GRAY;
            idx           <= '0;
            VEC           <= vg_vec;
            BUSY          <= 1'b1;
            settle_cnt    <= SETTLE_LD;
         end

         if (cnt_dec) begin
            settle_cnt <= settle_cnt - SW'(1);
         end

         if (do_sample) begin
            q_prev <= DUT_Q;
            ONES   <= ONES + {{NIN{1'b0}}, DUT_Q};
            if ((idx != '0) && (DUT_Q != q_prev)) begin
               TOGGLES <= TOGGLES + (NIN+1)'(1);
            end
            if (mismatch) begin
               ERRS <= ERRS + (NIN+1)'(1);
               if (!ERR_SEEN) begin
                  FIRST_ERR_IDX <= VEC;
                  ERR_SEEN      <= 1'b1;
               end
            end
            if (do_finish) begin
               BUSY <= 1'b0;
               DONE <= 1'b1;
               VEC  <= '0;
            end else begin
               idx        <= vg_idx;
               VEC        <= vg_vec;
               settle_cnt <= SETTLE_LD;
            end
         end

         // Partial counts are kept; the sample that would have landed is dropped.
         if (do_abort) begin
            BUSY <= 1'b0;
            VEC  <= '0;
         end
      end
   end

endmodule
